// File: rtl/debounce_multi_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Optional long-press support is enabled with the DEBOUNCE_LONG_PRESS_EN macro.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button-side bus of the debouncer: raw inputs in, debounced levels and pulses out.
// Optional long-press support is enabled with the DEBOUNCE_LONG_PRESS_EN macro.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  // No valid/ready handshake: btn_in is an asynchronous level, every output is
  // a registered Moore signal that is meaningful on every clock cycle.
  logic [N_CH-1:0]   btn_in;
  logic [N_CH-1:0]   db_out;
  logic [N_CH-1:0]   press_pulse;
  logic [N_CH-1:0]   release_pulse;
  logic [N_CH-1:0]   long_press;
  logic [2*N_CH-1:0] dbg_state;

  modport master (
    output btn_in,
    input  db_out, press_pulse, release_pulse, long_press, dbg_state
  );

  modport slave (
    input  btn_in,
    output db_out, press_pulse, release_pulse, long_press, dbg_state
  );
endinterface

// File: rtl/debounce_multi_ch.sv
// One debounce channel: 2-FF synchroniser, 4-state FSM with continuous-stability counter,
// press/release pulses and, with DEBOUNCE_LONG_PRESS_EN defined, a long-press pulse.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int DEBOUNCE_TIME_MS = 10,
  parameter int ACTIVE_LOW       = 1,
  parameter int LONG_PRESS_MS    = 1000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_btn,
  output logic      o_db,
  output logic      o_press,
  output logic      o_release,
  output logic      o_long,
  output db_state_t o_state
);

  localparam int   COUNT      = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_TIME_MS);
  localparam int   CW         = $clog2(COUNT + 1);
  localparam int   LONG_COUNT = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam logic INACTIVE   = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  if (COUNT < 2) begin : g_bad_count
    $error("debounce_ch: debounce count must be at least 2");
  end
  if (LONG_COUNT < 2) begin : g_bad_long
    $error("debounce_ch: long-press count must be at least 2");
  end

  logic            r_sync0, r_sync1;
  logic            w_btn;
  db_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_press, r_release;
  logic            w_press_nxt, w_release_nxt;

  // Polarity is folded in after the synchroniser so w_btn is always 1 = pressed.
  assign w_btn = r_sync1 ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0   <= INACTIVE;
      r_sync1   <= INACTIVE;
      r_state   <= IDLE_LO;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync0   <= i_btn;
      r_sync1   <= r_sync0;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE_LO: begin
        if (w_btn) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!w_btn) begin
          w_state_nxt = IDLE_LO;
        end else if (r_cnt == LAST) begin
          w_state_nxt = IDLE_HI;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!w_btn) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (w_btn) begin
          w_state_nxt = IDLE_HI;
        end else if (r_cnt == LAST) begin
          w_state_nxt   = IDLE_LO;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_db      = (r_state == IDLE_HI) || (r_state == WAIT_LO);
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_state   = r_state;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_COUNT + 1);

  logic [LW-1:0] r_lcnt;
  logic          r_long;

  // Hold time runs from the press through release bounces; only a real release clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_state_nxt == IDLE_LO) begin
        r_lcnt <= '0;
      end else if (r_state == WAIT_HI && w_state_nxt == IDLE_HI) begin
        r_lcnt <= '0;
      end else if (r_state == IDLE_HI || r_state == WAIT_LO) begin
        if (r_lcnt != LW'(LONG_COUNT)) begin
          r_lcnt <= r_lcnt + 1'b1;
        end
        r_long <= (r_lcnt == LW'(LONG_COUNT - 1));
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer: independent debounce_ch per input bit.
// Optional long-press pulse is enabled with the DEBOUNCE_LONG_PRESS_EN macro.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int DEBOUNCE_TIME_MS = 10,
  parameter int ACTIVE_LOW       = 1,
  parameter int LONG_PRESS_MS    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  debounce_multi_if.slave   bus
);

  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_multi: N_CH must be at least 1");
  end

  logic [N_CH-1:0]   w_db, w_press, w_release, w_long;
  db_state_t         w_state [N_CH];
  logic [2*N_CH-1:0] w_dbg;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .CLK_FREQ_HZ      (CLK_FREQ_HZ),
      .DEBOUNCE_TIME_MS (DEBOUNCE_TIME_MS),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_MS    (LONG_PRESS_MS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (bus.btn_in[g]),
      .o_db      (w_db[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_long    (w_long[g]),
      .o_state   (w_state[g])
    );
  end

  always_comb begin
    w_dbg = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dbg[2*i +: 2] = w_state[i];
    end
  end

  assign bus.db_out        = w_db;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.long_press    = w_long;
  assign bus.dbg_state     = w_dbg;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: an active-low and an active-high instance driven with the same
// pressed pattern, compared every cycle against a sample-window reference model.
module tb_debounce_multi;
  import debounce_pkg::*;

  localparam int N_CH       = 4;
  localparam int CLK_HZ     = 10_000;
  localparam int DB_MS      = 1;
  localparam int LP_MS      = 5;
  localparam int COUNT      = 10;
  localparam int LONG_COUNT = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debounce_multi_if #(.N_CH(N_CH)) bus_a ();
  debounce_multi_if #(.N_CH(N_CH)) bus_b ();

  debounce_multi #(
    .N_CH(N_CH), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_TIME_MS(DB_MS),
    .ACTIVE_LOW(1), .LONG_PRESS_MS(LP_MS)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  debounce_multi #(
    .N_CH(N_CH), .CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_TIME_MS(DB_MS),
    .ACTIVE_LOW(0), .LONG_PRESS_MS(LP_MS)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pressed-level sample history per channel
  bit              hq [N_CH][$];
  logic [N_CH-1:0] m_db, m_press, m_rel, m_long;
  int              t = 0;
  int              rise_t [N_CH];
  int              obs_press [N_CH];
  int              obs_rel [N_CH];
  int              obs_long [N_CH];

  task automatic model_edge(input logic [N_CH-1:0] btn, input logic r);
    t++;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (r) begin
        hq[ch].delete();
        repeat (COUNT + 3) hq[ch].push_back(1'b0);
        m_db[ch] = 1'b0;
      end else begin
        bit flip;
        int last;
        hq[ch].push_back(!btn[ch]);
        if (hq[ch].size() > COUNT + 3) hq[ch].delete(0);
        // The level changes once the last COUNT+1 samples that have crossed the
        // two-stage synchroniser all disagree with the current level.
        flip = (hq[ch].size() >= COUNT + 3);
        last = hq[ch].size() - 3;
        for (int k = 0; k <= COUNT; k++) begin
          if (flip && hq[ch][last-k] == m_db[ch]) flip = 1'b0;
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (m_db[ch] && !flip && (t - rise_t[ch] == LONG_COUNT)) m_long[ch] = 1'b1;
`endif
        if (flip) begin
          m_press[ch] = !m_db[ch];
          m_rel[ch]   = m_db[ch];
          m_db[ch]    = !m_db[ch];
          if (m_db[ch]) rise_t[ch] = t;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("a_db_out",        bus_a.db_out,        m_db);
    check("a_press_pulse",   bus_a.press_pulse,   m_press);
    check("a_release_pulse", bus_a.release_pulse, m_rel);
    check("a_long_press",    bus_a.long_press,    m_long);
    check("b_db_out",        bus_b.db_out,        m_db);
    check("b_press_pulse",   bus_b.press_pulse,   m_press);
    check("b_release_pulse", bus_b.release_pulse, m_rel);
    check("b_long_press",    bus_b.long_press,    m_long);
  endtask

  // driver: btn is the raw active-low pattern; the active-high instance gets its inverse
  task automatic step(input logic [N_CH-1:0] btn, input logic r);
    bus_a.btn_in = btn;
    bus_b.btn_in = ~btn;
    rst          = r;
    @(posedge clk);
    model_edge(btn, r);
    #1;
    check_outputs();
    for (int ch = 0; ch < N_CH; ch++) begin
      obs_press[ch] += int'(bus_a.press_pulse[ch]);
      obs_rel[ch]   += int'(bus_a.release_pulse[ch]);
      obs_long[ch]  += int'(bus_a.long_press[ch]);
    end
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < N_CH; ch++) begin
      obs_press[ch] = 0;
      obs_rel[ch]   = 0;
      obs_long[ch]  = 0;
    end
  endtask

  // Apply btn until db_out[ch] reaches level; lat = edges after the first sampling edge.
  task automatic wait_db(input int ch, input logic [N_CH-1:0] btn, input logic level,
                         output int lat, output logic [N_CH-1:0] pr, output logic [N_CH-1:0] rl);
    lat = -1;
    pr  = '0;
    rl  = '0;
    for (int n = 1; n <= 40; n++) begin
      step(btn, 1'b0);
      if (bus_a.db_out[ch] === level) begin
        lat = n - 1;
        pr  = bus_a.press_pulse;
        rl  = bus_a.release_pulse;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N_CH-1:0] btn;
    int              cycles;
    logic [N_CH-1:0] exp_db;
    logic [N_CH-1:0] exp_press;
    logic [N_CH-1:0] exp_rel;
  } phase_t;

  phase_t ph [10];

  initial begin
    int              lat;
    int              long_lat;
    logic [N_CH-1:0] pr, rl, pv, rv, mv;
    logic            drop;

    ph[0] = '{4'hF,  5, 4'h0, 4'h0, 4'h0};
    ph[1] = '{4'hE, 20, 4'h1, 4'h1, 4'h0};
    ph[2] = '{4'hF, 20, 4'h0, 4'h0, 4'h1};
    ph[3] = '{4'hD,  6, 4'h0, 4'h0, 4'h0};
    ph[4] = '{4'hF,  2, 4'h0, 4'h0, 4'h0};
    ph[5] = '{4'hD,  9, 4'h0, 4'h0, 4'h0};
    ph[6] = '{4'hF,  3, 4'h0, 4'h0, 4'h0};
    ph[7] = '{4'hD, 15, 4'h2, 4'h2, 4'h0};
    ph[8] = '{4'h0, 20, 4'hF, 4'hD, 4'h0};
    ph[9] = '{4'hF, 20, 4'h0, 4'h0, 4'hF};

    // reset
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("reset_db_out", bus_a.db_out, 4'h0);
    check("reset_pulses", {bus_a.press_pulse, bus_a.release_pulse, bus_a.long_press}, 12'h0);

    // table-driven phases
    for (int p = 0; p < 10; p++) begin
      clear_obs();
      repeat (ph[p].cycles) step(ph[p].btn, 1'b0);
      pv = '0; rv = '0; mv = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        pv[ch] = (obs_press[ch] != 0);
        rv[ch] = (obs_rel[ch] != 0);
        mv[ch] = (obs_press[ch] > 1) || (obs_rel[ch] > 1);
      end
      check($sformatf("phase%0d_db", p),      bus_a.db_out, ph[p].exp_db);
      check($sformatf("phase%0d_press", p),   pv, ph[p].exp_press);
      check($sformatf("phase%0d_release", p), rv, ph[p].exp_rel);
      check($sformatf("phase%0d_multi", p),   mv, 4'h0);
    end

    // clean press on channel 0
    repeat (15) step(4'hF, 1'b0);
    wait_db(0, 4'hE, 1'b1, lat, pr, rl);
    check("clean_press_latency", lat, 12);
    check("clean_press_pulse", pr, 4'h1);
    check("clean_press_others", bus_a.db_out, 4'h1);
    repeat (5) step(4'hE, 1'b0);

    // release with a 3-cycle glitch
    clear_obs();
    drop = 1'b0;
    repeat (4) begin step(4'hF, 1'b0); drop |= !bus_a.db_out[0]; end
    repeat (3) begin step(4'hE, 1'b0); drop |= !bus_a.db_out[0]; end
    check("glitch_db_held", drop, 1'b0);
    wait_db(0, 4'hF, 1'b0, lat, pr, rl);
    check("release_latency", lat, 12);
    check("release_pulse", rl, 4'h1);
    repeat (5) step(4'hF, 1'b0);
    check("release_single", obs_rel[0], 1);

    // reset five cycles into WAIT_HI
    repeat (15) step(4'hF, 1'b0);
    repeat (7) step(4'hB, 1'b0);
    step(4'hB, 1'b1);
    check("midwait_reset_out", {bus_a.db_out, bus_a.press_pulse, bus_a.release_pulse, bus_a.long_press}, 16'h0);
    clear_obs();
    wait_db(2, 4'hB, 1'b1, lat, pr, rl);
    check("after_reset_latency", lat, 12);
    check("after_reset_press", pr, 4'h4);
    repeat (5) step(4'hB, 1'b0);
    check("after_reset_single", obs_press[2], 1);

    // all channels together, then hold for long press
    repeat (20) step(4'hF, 1'b0);
    wait_db(0, 4'h0, 1'b1, lat, pr, rl);
    check("parallel_latency", lat, 12);
    check("parallel_press_a", pr, 4'hF);
    check("parallel_press_b", bus_b.press_pulse, 4'hF);
    check("parallel_db", bus_a.db_out, 4'hF);
    clear_obs();
    long_lat = -1;
    for (int n = 1; n <= 70; n++) begin
      step(4'h0, 1'b0);
      if (long_lat < 0 && bus_a.long_press[0] === 1'b1) long_lat = n;
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    check("long_latency", long_lat, LONG_COUNT);
    check("long_count", obs_long[0], 1);
`else
    check("long_latency", long_lat, -1);
    check("long_count", obs_long[0], 0);
`endif
    repeat (20) step(4'hF, 1'b0);

    // randomized bouncing with occasional reset
    begin
      logic [N_CH-1:0] lvl;
      int              hold [N_CH];
      lvl = 4'hF;
      for (int ch = 0; ch < N_CH; ch++) hold[ch] = 0;
      for (int n = 0; n < 900; n++) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (hold[ch] == 0) begin
            lvl[ch]  = ~lvl[ch];
            hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 70) : $urandom_range(1, 14);
          end
          hold[ch]--;
        end
        step(lvl, $urandom_range(0, 299) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
